// File: rtl/pipe_memory_stage_if.sv
// pipe_memory_stage_if: execute-to-memory fields in, forwarding and writeback register out
interface pipe_memory_stage_if;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic        W_stall;
    logic        W_bubble;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    modport master (
        output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
        input  m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );
    modport slave (
        input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
        output m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );
endinterface

// File: rtl/pipe_memory_stage.sv
// pipe_memory_stage: Y86-64 data-memory access with the memory-to-writeback pipeline register
module pipe_memory_stage #(
    parameter int DMEM_BYTES = 1024,
    parameter int ADDR_W     = 64
) (
    input logic              clk,
    input logic              rst,
    pipe_memory_stage_if.slave bus
);
    localparam int idx_w = $clog2(DMEM_BYTES);
    localparam logic [ADDR_W-1:0] addr_max = ADDR_W'(DMEM_BYTES - 8);
    localparam logic [2:0] s_aok = 3'd1;
    localparam logic [2:0] s_adr = 3'd3;
    localparam logic [3:0] i_nop = 4'h1;
    localparam logic [3:0] i_rmmovq = 4'h4;
    localparam logic [3:0] i_mrmovq = 4'h5;
    localparam logic [3:0] i_call = 4'h8;
    localparam logic [3:0] i_ret = 4'h9;
    localparam logic [3:0] i_pushq = 4'hA;
    localparam logic [3:0] i_popq = 4'hB;
    localparam logic [3:0] r_none = 4'hF;

    logic [7:0]        mem [DMEM_BYTES];
    logic [ADDR_W-1:0] addr;
    logic [idx_w-1:0]  base;
    logic              rd, wr, err;

    // Unsigned full-width compare keeps addresses near 2^64 from wrapping into range
    always_comb begin
        wr = bus.M_icode == i_rmmovq || bus.M_icode == i_call || bus.M_icode == i_pushq;
        rd = bus.M_icode == i_mrmovq || bus.M_icode == i_ret || bus.M_icode == i_popq;
        addr = (wr || bus.M_icode == i_mrmovq) ? bus.M_valE[ADDR_W-1:0]
             : rd ? bus.M_valA[ADDR_W-1:0] : '0;
        err = (rd || wr) && addr > addr_max;
        base = addr[idx_w-1:0];
        bus.m_valM = '0;
        for (int i = 0; i < 8; i++)
            bus.m_valM[8*i +: 8] = (rd && !err) ? mem[base + idx_w'(i)] : 8'h00;
        bus.m_stat = err ? s_adr : bus.M_stat;
    end

    always_ff @(posedge clk) begin
        if (rst)
            for (int i = 0; i < DMEM_BYTES; i++) mem[i] <= 8'h00;
        else if (wr && !err && bus.M_stat == s_aok)
            for (int i = 0; i < 8; i++) mem[base + idx_w'(i)] <= bus.M_valA[8*i +: 8];
    end

    // Stall gates only this register; memory writes above proceed regardless
    always_ff @(posedge clk) begin
        if (rst || (bus.W_bubble && !bus.W_stall)) begin
            bus.W_stat  <= s_aok;
            bus.W_icode <= i_nop;
            bus.W_valE  <= '0;
            bus.W_valM  <= '0;
            bus.W_dstE  <= r_none;
            bus.W_dstM  <= r_none;
        end else if (!bus.W_stall) begin
            bus.W_stat  <= bus.m_stat;
            bus.W_icode <= bus.M_icode;
            bus.W_valE  <= bus.M_valE;
            bus.W_valM  <= bus.m_valM;
            bus.W_dstE  <= bus.M_dstE;
            bus.W_dstM  <= bus.M_dstM;
        end
    end
endmodule

// File: tb/tb_pipe_memory_stage.sv
// tb_pipe_memory_stage: directed plus random checks against a byte-array reference model
module tb_pipe_memory_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    byte unsigned mm [1024];
    logic [2:0]  w_stat;
    logic [3:0]  w_icode, w_dstE, w_dstM;
    logic [63:0] w_valE, w_valM, saved_valE, saved_valM;
    logic [3:0]  saved_icode;

    pipe_memory_stage_if bus();
    pipe_memory_stage #(.DMEM_BYTES(1024), .ADDR_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                       input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                       input logic stall, input logic bubble);
        bus.M_stat = st; bus.M_icode = ic; bus.M_valE = ve; bus.M_valA = va;
        bus.M_dstE = de; bus.M_dstM = dm; bus.W_stall = stall; bus.W_bubble = bubble;
        bus.M_cnd = 1'($urandom);
    endtask

    task automatic step();
        logic [63:0] a, vm;
        logic [2:0] ms;
        bit rd, wr, err;
        rd = bus.M_icode inside {4'h5, 4'h9, 4'hB};
        wr = bus.M_icode inside {4'h4, 4'h8, 4'hA};
        a = (bus.M_icode inside {4'h4, 4'h5, 4'h8, 4'hA}) ? bus.M_valE
          : (bus.M_icode inside {4'h9, 4'hB}) ? bus.M_valA : 64'd0;
        err = (rd || wr) && a > 64'd1016;
        vm = 64'd0;
        if (rd && !err)
            for (int k = 0; k < 8; k++) vm = vm | (64'(mm[int'(a) + k]) << (8 * k));
        ms = err ? 3'd3 : bus.M_stat;
        @(negedge clk);
        chk("m_valM", bus.m_valM, vm);
        chk("m_stat", 64'(bus.m_stat), 64'(ms));
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 1024; k++) mm[k] = 8'h00;
        end else if (wr && !err && bus.M_stat == 3'd1) begin
            for (int k = 0; k < 8; k++) mm[int'(a) + k] = bus.M_valA[8*k +: 8];
        end
        if (rst || (bus.W_bubble && !bus.W_stall)) begin
            w_stat = 3'd1; w_icode = 4'h1; w_valE = 64'd0; w_valM = 64'd0; w_dstE = 4'hF; w_dstM = 4'hF;
        end else if (!bus.W_stall) begin
            w_stat = ms; w_icode = bus.M_icode; w_valE = bus.M_valE; w_valM = vm;
            w_dstE = bus.M_dstE; w_dstM = bus.M_dstM;
        end
        #1;
        chk("W_stat", 64'(bus.W_stat), 64'(w_stat));
        chk("W_icode", 64'(bus.W_icode), 64'(w_icode));
        chk("W_valE", bus.W_valE, w_valE);
        chk("W_valM", bus.W_valM, w_valM);
        chk("W_dstE", 64'(bus.W_dstE), 64'(w_dstE));
        chk("W_dstM", 64'(bus.W_dstM), 64'(w_dstM));
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 5))
            0: return 64'($urandom_range(1000, 1030));
            1: return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            default: return 64'($urandom_range(0, 127)) * 8 + 64'($urandom_range(0, 1) * $urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        set(3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
        step();
        chk("rst_icode", 64'(bus.W_icode), 64'h1);
        chk("rst_dstE", 64'(bus.W_dstE), 64'hF);
        rst = 1'b0;
        set(3'd1, 4'h4, 64'h10, 64'h0123456789ABCDEF, 4'hF, 4'hF, 1'b0, 1'b0);
        step();
        set(3'd1, 4'h5, 64'h10, 64'd0, 4'hF, 4'h3, 1'b0, 1'b0);
        step();
        chk("byte10", 64'(bus.m_valM[7:0]), 64'hEF);
        chk("ld_valM", bus.W_valM, 64'h0123456789ABCDEF);
        chk("ld_dstM", 64'(bus.W_dstM), 64'h3);
        set(3'd1, 4'h5, 64'd1017, 64'd0, 4'hF, 4'h2, 1'b0, 1'b0);
        step();
        chk("err_Wstat", 64'(bus.W_stat), 64'h3);
        chk("err_valM", bus.W_valM, 64'd0);
        set(3'd1, 4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEAD_BEEF_0000_1111, 4'hF, 4'hF, 1'b0, 1'b0);
        step();
        chk("wrap_mstat", 64'(bus.m_stat), 64'h3);
        set(3'd1, 4'h5, 64'h3F8, 64'd0, 4'hF, 4'h1, 1'b0, 1'b0);
        step();
        chk("wrap_nowrite", bus.W_valM, 64'd0);
        set(3'd1, 4'hA, 64'h20, 64'h5555555555555555, 4'h4, 4'hF, 1'b0, 1'b0);
        step();
        set(3'd1, 4'hB, 64'h28, 64'h20, 4'h4, 4'h7, 1'b0, 1'b0);
        step();
        chk("pop_valM", bus.W_valM, 64'h5555555555555555);
        chk("pop_valE", bus.W_valE, 64'h28);
        saved_icode = bus.W_icode; saved_valE = bus.W_valE; saved_valM = bus.W_valM;
        for (int i = 0; i < 2; i++) begin
            set(3'd1, 4'h5, 64'h10, 64'd0, 4'h2, 4'h6, 1'b1, 1'b0);
            step();
        end
        set(3'd1, 4'h6, 64'h99, 64'd0, 4'h2, 4'h6, 1'b1, 1'b1);
        step();
        chk("stall_icode", 64'(bus.W_icode), 64'(saved_icode));
        chk("stall_valE", bus.W_valE, saved_valE);
        chk("stall_valM", bus.W_valM, saved_valM);
        set(3'd1, 4'h6, 64'h99, 64'd0, 4'h2, 4'h6, 1'b0, 1'b1);
        step();
        chk("bub_icode", 64'(bus.W_icode), 64'h1);
        chk("bub_dstE", 64'(bus.W_dstE), 64'hF);
        set(3'd4, 4'h4, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 4'hF, 1'b0, 1'b0);
        step();
        chk("ins_mstat", 64'(bus.m_stat), 64'h4);
        set(3'd1, 4'h5, 64'h40, 64'd0, 4'hF, 4'h1, 1'b0, 1'b0);
        step();
        chk("ins_nowrite", bus.W_valM, 64'd0);
        rst = 1'b1;
        set(3'd1, 4'h4, 64'h60, 64'hCAFE_F00D_1234_5678, 4'hF, 4'hF, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        set(3'd1, 4'h5, 64'h60, 64'd0, 4'hF, 4'h1, 1'b0, 1'b0);
        step();
        chk("rst_nowrite", bus.W_valM, 64'd0);
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 60) == 0);
            set(($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'd1,
                ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'(4 + $urandom_range(0, 7)),
                rand_addr(), ($urandom_range(0, 1) == 1) ? rand_addr() : {$urandom, $urandom},
                4'($urandom), 4'($urandom),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
